// File: rtl/ex_mem_pkg.sv
// Shared widths, stall indices, constants and payload types for the EX/MEM pipeline register.
// Optional stall performance counters are enabled with EX_MEM_STALL_PERF_EN.
package ex_mem_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned HILO_W  = 2 * DATA_W;
  localparam int unsigned PERF_W  = 32;

  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;

  localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;
  localparam logic              RST_ENABLE    = 1'b1;

  // What the register does on an edge once rst and flush have been ruled out.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_ILLEGAL = 2'd3
  } stage_act_e;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mem_payload_t;

  typedef struct packed {
    logic [HILO_W-1:0] hilo;
    logic [CNT_W-1:0]  cnt;
  } loop_state_t;

  // Only the EX and MEM stall bits matter to this stage.
  function automatic stage_act_e stall_decode(input logic ex_stall, input logic mem_stall);
    stage_act_e act;
    unique case ({ex_stall, mem_stall})
      2'b00:   act = ACT_ADVANCE;
      2'b10:   act = ACT_BUBBLE;
      2'b11:   act = ACT_HOLD;
      default: act = ACT_ILLEGAL;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM stage bus: execute results and stall control in, memory-stage results and loop-back out.
// bubble_cnt/hold_cnt exist only when EX_MEM_STALL_PERF_EN is defined.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic [STALL_W-1:0] stall;
  logic               flush;

  logic [ADDR_W-1:0]  ex_wd;
  logic               ex_wreg;
  logic [DATA_W-1:0]  ex_wdata;
  logic               ex_whilo;
  logic [DATA_W-1:0]  ex_hi;
  logic [DATA_W-1:0]  ex_lo;
  logic [HILO_W-1:0]  hilo_i;
  logic [CNT_W-1:0]   cnt_i;

  logic [ADDR_W-1:0]  mem_wd;
  logic               mem_wreg;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_whilo;
  logic [DATA_W-1:0]  mem_hi;
  logic [DATA_W-1:0]  mem_lo;
  logic [HILO_W-1:0]  hilo_o;
  logic [CNT_W-1:0]   cnt_o;

`ifdef EX_MEM_STALL_PERF_EN
  logic [PERF_W-1:0]  bubble_cnt;
  logic [PERF_W-1:0]  hold_cnt;
`endif

  // Pipeline register side.
  modport slave (
    input  stall, flush,
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
`ifdef EX_MEM_STALL_PERF_EN
    , output bubble_cnt, output hold_cnt
`endif
  );

  // Execute stage / stall controller side.
  modport master (
    output stall, flush,
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
`ifdef EX_MEM_STALL_PERF_EN
    , input bubble_cnt, input hold_cnt
`endif
  );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: advance, bubble or hold per the stall vector; flush clears everything.
// Define EX_MEM_STALL_PERF_EN to add bubble/hold cycle counters.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_mem_if.slave  bus
);

  mem_payload_t mem_q, mem_d;
  loop_state_t  loop_q, loop_d;
  mem_payload_t ex_payload_c;
  stage_act_e   act_c;
  logic         stall_unused_c;

  assign act_c = stall_decode(bus.stall[STALL_EX], bus.stall[STALL_MEM]);
  assign stall_unused_c = ^{bus.stall[STALL_W-1], bus.stall[STALL_EX-1:0]};

  always_comb begin
    ex_payload_c       = '0;
    ex_payload_c.wd    = bus.ex_wd;
    ex_payload_c.wreg  = bus.ex_wreg ? WRITE_ENABLE : WRITE_DISABLE;
    ex_payload_c.wdata = bus.ex_wdata;
    ex_payload_c.whilo = bus.ex_whilo ? WRITE_ENABLE : WRITE_DISABLE;
    ex_payload_c.hi    = bus.ex_hi;
    ex_payload_c.lo    = bus.ex_lo;
  end

  // Next-state: flush aborts everything, otherwise follow the stall decode.
  always_comb begin
    mem_d  = mem_q;
    loop_d = loop_q;
    if (bus.flush) begin
      mem_d  = '0;
      loop_d = '0;
    end else begin
      unique case (act_c)
        ACT_ADVANCE: begin
          mem_d  = ex_payload_c;
          loop_d = '0;
        end
        ACT_BUBBLE: begin
          mem_d.wd    = '0;
          mem_d.wreg  = WRITE_DISABLE;
          mem_d.wdata = ZERO_WORD;
          mem_d.whilo = WRITE_DISABLE;
          mem_d.hi    = ZERO_WORD;
          mem_d.lo    = ZERO_WORD;
          loop_d.hilo = bus.hilo_i;
          loop_d.cnt  = bus.cnt_i;
        end
        default: begin
          mem_d  = mem_q;
          loop_d = loop_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mem_q  <= '0;
      loop_q <= '0;
    end else begin
      mem_q  <= mem_d;
      loop_q <= loop_d;
    end
  end

  assign bus.mem_wd    = mem_q.wd;
  assign bus.mem_wreg  = mem_q.wreg;
  assign bus.mem_wdata = mem_q.wdata;
  assign bus.mem_whilo = mem_q.whilo;
  assign bus.mem_hi    = mem_q.hi;
  assign bus.mem_lo    = mem_q.lo;
  assign bus.hilo_o    = loop_q.hilo;
  assign bus.cnt_o     = loop_q.cnt;

`ifdef EX_MEM_STALL_PERF_EN
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [PERF_W-1:0] hold_cnt_q, hold_cnt_d;

  // Flush edges are not bubble/hold edges, so neither counter moves on them.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (!bus.flush) begin
      if (act_c == ACT_BUBBLE) begin
        bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
      end
      if (act_c == ACT_HOLD || act_c == ACT_ILLEGAL) begin
        hold_cnt_d = hold_cnt_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.hold_cnt   = hold_cnt_q;
`endif

  // EX running while MEM is stalled would drop an instruction; it is held instead.
  illegal_stall_a: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
                                    act_c != ACT_ILLEGAL);

endmodule
